mult_sgf_norm_round: RTL and testbench

Normalization and rounding stage placed directly downstream of the recursive Karatsuba significand multiplier in the FPU multiply path. It captures the registered 2·SW-bit significand product and the pre-computed biased exponent sum. It then normalizes the product to a SW-bit significand with hidden bit, rounds it per IEEE-754 mode, re-normalizes on round carry-out, and flags exponent overflow/underflow. It runs as a 4-state sequential unit with a load/ready handshake to the FPU control FSM.

---
 rtl/mult_sgf_norm_round_pkg.sv | 20 ++
 rtl/mult_sgf_norm_round_if.sv | 28 ++
 rtl/mult_sgf_norm_round_round_decide.sv | 25 ++
 rtl/mult_sgf_norm_round.sv | 175 +++++++++++++++++
 tb/tb_mult_sgf_norm_round.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mult_sgf_norm_round_pkg.sv
// Shared FPU definitions: rounding-mode encodings, default widths and the
// normalize/round stage state encoding.
package mult_sgf_norm_round_pkg;

   localparam int SW_DEF = 24;
   localparam int EW_DEF = 8;

   localparam logic [1:0] RM_RNE  = 2'b00;
   localparam logic [1:0] RM_RZ   = 2'b01;
   localparam logic [1:0] RM_PINF = 2'b10;
   localparam logic [1:0] RM_NINF = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_POST  = 2'd3
   } nr_state_t;

endpackage

// File: rtl/mult_sgf_norm_round_if.sv
// Load/ready handshake and data bus between the FPU control FSM (master)
// and the significand normalize/round stage (slave).
interface mult_sgf_norm_round_if #(
   parameter int SW = 24,
   parameter int EW = 8
);
   logic              load_i;
   logic [2*SW-1:0]   sgf_prod_i;
   logic [EW:0]       exp_i;
   logic              sign_i;
   logic [1:0]        rmode_i;
   logic              busy_o;
   logic              ready_o;
   logic [SW-1:0]     sgf_o;
   logic [EW-1:0]     exp_o;
   logic              ovf_o;
   logic              unf_o;

   modport master (
      output load_i, sgf_prod_i, exp_i, sign_i, rmode_i,
      input  busy_o, ready_o, sgf_o, exp_o, ovf_o, unf_o
   );

   modport slave (
      input  load_i, sgf_prod_i, exp_i, sign_i, rmode_i,
      output busy_o, ready_o, sgf_o, exp_o, ovf_o, unf_o
   );
endinterface

// File: rtl/mult_sgf_norm_round_round_decide.sv
// IEEE-754 increment decision from guard, sticky, kept LSB and sign.
// Purely combinational; shared with the adder-path rounder.
module round_decide
   import mult_sgf_norm_round_pkg::*;
(
   input  logic       g,
   input  logic       s,
   input  logic       lsb,
   input  logic       sign,
   input  logic [1:0] rmode,
   output logic       inc
);

   always_comb begin
      inc = 1'b0;
      unique case (rmode)
         RM_RNE:  inc = g & (s | lsb);
         RM_RZ:   inc = 1'b0;
         RM_PINF: inc = (g | s) & ~sign;
         RM_NINF: inc = (g | s) & sign;
         default: inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/mult_sgf_norm_round.sv
// Normalize/round stage behind the significand multiplier: capture, 1-bit
// normalize, round, re-normalize on carry-out, exponent flags.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for load_i; captures product, exponent, sign, mode
//  ST_NORM  | selects kept bits, guard, sticky; bumps exponent if MSB set
//  ST_ROUND | adds rounding increment into SW+1 bit sum
//  ST_POST  | re-normalizes carry-out, computes flags, writes outputs
module mult_sgf_norm_round
   import mult_sgf_norm_round_pkg::*;
#(
   parameter int SW = SW_DEF,
   parameter int EW = EW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   mult_sgf_norm_round_if.slave  bus
);

   localparam logic [EW+1:0] EXP_MAX = {2'b00, {EW{1'b1}}};

   nr_state_t        state_q, state_d;

   logic [2*SW-1:0]  prod_q;
   logic [EW+1:0]    exp_q;
   logic             sign_q;
   logic [1:0]       rmode_q;
   logic [SW-1:0]    kept_q;
   logic             g_q;
   logic             s_q;
   logic [SW:0]      sum_q;

   logic             ready_q;
   logic [SW-1:0]    sgf_out_q;
   logic [EW-1:0]    exp_out_q;
   logic             ovf_q;
   logic             unf_q;

   logic             cap_en;
   logic             prod_hi;
   logic [SW-1:0]    kept_n;
   logic             g_n;
   logic             s_n;
   logic             inc;
   logic [SW:0]      sum_n;
   logic [EW+1:0]    exp_fin;
   logic [SW-1:0]    sgf_fin;
   logic             ovf_fin;
   logic             unf_fin;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cap_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.load_i) begin
               cap_en  = 1'b1;
               state_d = ST_NORM;
            end
         end
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: state_d = ST_POST;
         ST_POST:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   // Product of two normalized significands lies in [1,4): at most one
   // right shift is needed, selected by the top product bit.
   always_comb begin
      prod_hi = prod_q[2*SW-1];
      if (prod_hi) begin
         kept_n = prod_q[2*SW-1:SW];
         g_n    = prod_q[SW-1];
         s_n    = |prod_q[SW-2:0];
      end else begin
         kept_n = prod_q[2*SW-2:SW-1];
         g_n    = prod_q[SW-2];
         s_n    = |prod_q[SW-3:0];
      end
   end

   round_decide u_round_decide (
      .g     (g_q),
      .s     (s_q),
      .lsb   (kept_q[0]),
      .sign  (sign_q),
      .rmode (rmode_q),
      .inc   (inc)
   );

   assign sum_n = {1'b0, kept_q} + {{SW{1'b0}}, inc};

   // A carry-out can only come from an all-ones mantissa, so the shifted
   // result is exactly 1.000...0.
   always_comb begin
      exp_fin = exp_q + {{(EW+1){1'b0}}, sum_q[SW]};
      sgf_fin = sum_q[SW] ? sum_q[SW:1] : sum_q[SW-1:0];
      ovf_fin = (exp_fin >= EXP_MAX);
      unf_fin = (exp_fin == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q  <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         rmode_q <= RM_RNE;
         kept_q  <= '0;
         g_q     <= 1'b0;
         s_q     <= 1'b0;
         sum_q   <= '0;
      end else begin
         if (cap_en) begin
            prod_q  <= bus.sgf_prod_i;
            exp_q   <= {1'b0, bus.exp_i};
            sign_q  <= bus.sign_i;
            rmode_q <= bus.rmode_i;
         end
         if (state_q == ST_NORM) begin
            kept_q <= kept_n;
            g_q    <= g_n;
            s_q    <= s_n;
            exp_q  <= exp_q + {{(EW+1){1'b0}}, prod_hi};
         end
         if (state_q == ST_ROUND) begin
            sum_q <= sum_n;
         end
      end
   end

   // Output registers: written once per operation, held until the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q   <= 1'b0;
         sgf_out_q <= '0;
         exp_out_q <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         ready_q <= (state_q == ST_POST);
         if (state_q == ST_POST) begin
            ovf_q <= ovf_fin;
            unf_q <= unf_fin;
            if (ovf_fin) begin
               sgf_out_q <= '0;
               exp_out_q <= '1;
            end else begin
               sgf_out_q <= sgf_fin;
               exp_out_q <= exp_fin[EW-1:0];
            end
         end
      end
   end

   assign bus.busy_o  = (state_q != ST_IDLE);
   assign bus.ready_o = ready_q;
   assign bus.sgf_o   = sgf_out_q;
   assign bus.exp_o   = exp_out_q;
   assign bus.ovf_o   = ovf_q;
   assign bus.unf_o   = unf_q;

endmodule

// File: tb/tb_mult_sgf_norm_round.sv
// Self-checking bench for mult_sgf_norm_round: directed vectors, control
// corner cases and random products against an arithmetic reference model.
module tb_mult_sgf_norm_round;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mult_sgf_norm_round_if #(.SW(24), .EW(8)) bus ();

   mult_sgf_norm_round #(.SW(24), .EW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [47:0] p;
      logic [8:0]  e;
      logic        s;
      logic [1:0]  rm;
      logic [23:0] sgf;
      logic [7:0]  ex;
      logic        ovf;
      logic        unf;
   } vec_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_chk++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   // Reference: value-level rounding of prod * 2^-shift, remainder vs half-ulp.
   function automatic logic [33:0] model(input logic [47:0] p, input logic [8:0] e,
                                         input logic s, input logic [1:0] rm);
      longint unsigned prod, kept, rem, half;
      int  sh, ex;
      bit  up;
      prod = 64'(p);
      sh   = p[47] ? 24 : 23;
      ex   = int'(e) + (p[47] ? 1 : 0);
      kept = prod >> sh;
      rem  = prod - (kept << sh);
      half = 64'd1 << (sh - 1);
      case (rm)
         2'b00:   up = (rem > half) || (rem == half && (kept % 2) == 1);
         2'b01:   up = 1'b0;
         2'b10:   up = (rem != 0) && !s;
         default: up = (rem != 0) && s;
      endcase
      kept = kept + (up ? 64'd1 : 64'd0);
      if (kept == (64'd1 << 24)) begin
         kept = kept >> 1;
         ex++;
      end
      if (ex >= 255) return {1'b1, 1'b0, 8'hFF, 24'h0};
      return {1'b0, (ex == 0), ex[7:0], kept[23:0]};
   endfunction

   // Starts at a negedge in IDLE, ends at the negedge of the ready cycle.
   task automatic do_op(input vec_t v, input bit noise);
      bus.load_i     = 1'b1;
      bus.sgf_prod_i = v.p;
      bus.exp_i      = v.e;
      bus.sign_i     = v.s;
      bus.rmode_i    = v.rm;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         bus.load_i = 1'b0;
         if (noise && c == 2) begin
            bus.load_i     = 1'b1;
            bus.sgf_prod_i = 48'hFFFF_FFFF_FFFF;
            bus.exp_i      = 9'h1FF;
            bus.rmode_i    = 2'b10;
         end
         chk("busy_mid", 64'(bus.busy_o), 64'd1);
         chk("ready_mid", 64'(bus.ready_o), 64'd0);
      end
      @(negedge clk);
      bus.load_i = 1'b0;
      chk("ready", 64'(bus.ready_o), 64'd1);
      chk("busy_done", 64'(bus.busy_o), 64'd0);
      chk("sgf", 64'(bus.sgf_o), 64'(v.sgf));
      chk("exp", 64'(bus.exp_o), 64'(v.ex));
      chk("ovf", 64'(bus.ovf_o), 64'(v.ovf));
      chk("unf", 64'(bus.unf_o), 64'(v.unf));
   endtask

   vec_t dir[$];

   initial begin
      vec_t v;
      logic [33:0] r;
      logic [23:0] a, b;

      rst            = 1'b1;
      bus.load_i     = 1'b1;
      bus.sgf_prod_i = 48'h4000_0000_0000;
      bus.exp_i      = 9'h07F;
      bus.sign_i     = 1'b0;
      bus.rmode_i    = 2'b00;
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_ready", 64'(bus.ready_o), 64'd0);
      chk("rst_sgf", 64'(bus.sgf_o), 64'd0);
      chk("rst_exp", 64'(bus.exp_o), 64'd0);
      chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
      chk("rst_unf", 64'(bus.unf_o), 64'd0);
      @(negedge clk);
      chk("rst_over_load", 64'(bus.busy_o), 64'd0);
      bus.load_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      //          product              exp     s     rm     sgf          exp    ovf   unf
      dir.push_back('{48'h4000_0000_0000, 9'h07F, 1'b0, 2'b00, 24'h800000, 8'h7F, 1'b0, 1'b0});
      dir.push_back('{48'h9000_0000_0000, 9'h07F, 1'b0, 2'b00, 24'h900000, 8'h80, 1'b0, 1'b0});
      dir.push_back('{48'h4000_0040_0000, 9'h07F, 1'b0, 2'b00, 24'h800000, 8'h7F, 1'b0, 1'b0});
      dir.push_back('{48'h4000_00C0_0000, 9'h07F, 1'b0, 2'b00, 24'h800002, 8'h7F, 1'b0, 1'b0});
      dir.push_back('{48'h4000_0040_0000, 9'h07F, 1'b0, 2'b10, 24'h800001, 8'h7F, 1'b0, 1'b0});
      dir.push_back('{48'h4000_0040_0000, 9'h07F, 1'b1, 2'b10, 24'h800000, 8'h7F, 1'b0, 1'b0});
      dir.push_back('{48'h4000_0040_0000, 9'h07F, 1'b1, 2'b11, 24'h800001, 8'h7F, 1'b0, 1'b0});
      dir.push_back('{48'h4000_00C0_0000, 9'h07F, 1'b0, 2'b01, 24'h800001, 8'h7F, 1'b0, 1'b0});
      dir.push_back('{48'h7FFF_FFC0_0000, 9'h07F, 1'b0, 2'b00, 24'h800000, 8'h80, 1'b0, 1'b0});
      dir.push_back('{48'h9000_0000_0000, 9'h0FE, 1'b0, 2'b00, 24'h000000, 8'hFF, 1'b1, 1'b0});
      dir.push_back('{48'h4000_0000_0000, 9'h000, 1'b0, 2'b00, 24'h800000, 8'h00, 1'b0, 1'b1});
      dir.push_back('{48'h9000_0000_0000, 9'h0FD, 1'b0, 2'b00, 24'h900000, 8'hFE, 1'b0, 1'b0});

      foreach (dir[i]) do_op(dir[i], (i % 3) == 1);

      // Reset in cycle k+2 aborts the operation started in cycle k.
      bus.load_i     = 1'b1;
      bus.sgf_prod_i = 48'h9000_0000_0000;
      bus.exp_i      = 9'h07F;
      @(negedge clk);
      bus.load_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(bus.busy_o), 64'd0);
      chk("abort_ready", 64'(bus.ready_o), 64'd0);
      chk("abort_sgf", 64'(bus.sgf_o), 64'd0);
      chk("abort_exp", 64'(bus.exp_o), 64'd0);
      chk("abort_ovf", 64'(bus.ovf_o), 64'd0);
      chk("abort_unf", 64'(bus.unf_o), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_no_ready", 64'(bus.ready_o), 64'd0);
      end

      for (int i = 0; i < 300; i++) begin
         a    = {1'b1, 23'($urandom)};
         b    = {1'b1, 23'($urandom)};
         v.p  = 48'(a) * 48'(b);
         if (i % 4 == 0) v.p[22:0] = (i % 8 == 0) ? 23'h400000 : 23'h0;
         v.e  = (i % 5 == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 3) + 9'h0FC * (i % 2));
         v.s  = 1'($urandom);
         v.rm = 2'($urandom);
         r    = model(v.p, v.e, v.s, v.rm);
         {v.ovf, v.unf, v.ex, v.sgf} = r;
         do_op(v, ($urandom_range(0, 3) == 0));
      end

      @(negedge clk);
      chk("ready_pulse_end", 64'(bus.ready_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
